// File: rtl/control_sequencer.sv
// Fetch/decode/sequencing FSM for the 4-bit accumulator datapath.
// Fetches byte-wide instructions as two nibbles and emits one-cycle datapath strobes.
module control_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [3:0]      data,
    input  logic            take_branch,
    input  logic            reg_is_zero,
    output logic [PC_W-1:0] rom_addr,
    output logic            nibble_sel,
    output logic            halt,
    output logic [3:0]      inst_operand,
    output logic            clear_carry,
    output logic            write_carry,
    output logic            clear_accumulator,
    output logic            write_accumulator,
    output logic            write_register,
    output logic [2:0]      acc_input_sel,
    output logic [1:0]      reg_input_sel,
    output logic [2:0]      alu_op,
    output logic [2:0]      alu_in0_sel,
    output logic [1:0]      alu_in1_sel,
    output logic [1:0]      alu_cin_sel
);

    // Datapath select encodings:
    // acc: 0 zero, 1 alu, 2 reg, 3 operand, 4 {000,carry}; reg: 0 zero, 1 alu, 2 acc
    // alu_op: 0 idle, 1 add; in0: 0 zero, 1 acc, 2 reg, 3 4'hF
    // in1: 0 zero, 1 reg, 2 ~reg; cin: 0 zero, 1 one, 2 carry, 3 ~carry
    localparam logic [2:0] ACC_ALU = 3'd1, ACC_REG = 3'd2, ACC_OPR = 3'd3, ACC_CY = 3'd4;
    localparam logic [1:0] REG_ALU = 2'd1, REG_ACC = 2'd2;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] IN0_ACC = 3'd1, IN0_REG = 3'd2, IN0_F = 3'd3;
    localparam logic [1:0] IN1_REG = 2'd1, IN1_NREG = 2'd2;
    localparam logic [1:0] CIN_ONE = 2'd1, CIN_CY = 2'd2, CIN_NCY = 2'd3;

    typedef enum logic [2:0] {
        FETCH_HI, FETCH_LO, FETCH2_HI, FETCH2_LO, EXEC, ISZ_BR, HALTED
    } state_t;

    typedef struct packed {
        logic       clr_cy;
        logic       wr_cy;
        logic       clr_acc;
        logic       wr_acc;
        logic       wr_reg;
        logic [2:0] acc_sel;
        logic [1:0] reg_sel;
        logic [2:0] op;
        logic [2:0] in0;
        logic [1:0] in1;
        logic [1:0] cin;
    } ctrl_t;

    state_t          state;
    ctrl_t           ctrl;
    logic [PC_W-1:0] pc;
    logic [3:0]      opcode, addr_hi, addr_lo;
    logic [PC_W-1:0] target;
    logic            two_byte;

    assign target   = PC_W'({addr_hi, addr_lo});
    assign two_byte = (opcode == 4'h1) || (opcode == 4'h4) || (opcode == 4'h7);

    function automatic ctrl_t decode(input logic [3:0] op, input logic [3:0] opr);
        ctrl_t c;
        c = '0;
        case (op)
            4'h6, 4'h7: begin
                c.op = ALU_ADD; c.in0 = IN0_REG; c.cin = CIN_ONE;
                c.reg_sel = REG_ALU; c.wr_reg = 1'b1;
            end
            4'h8: begin
                c.op = ALU_ADD; c.in0 = IN0_ACC; c.in1 = IN1_REG; c.cin = CIN_CY;
                c.acc_sel = ACC_ALU; c.wr_acc = 1'b1; c.wr_cy = 1'b1;
            end
            4'h9: begin
                c.op = ALU_ADD; c.in0 = IN0_ACC; c.in1 = IN1_NREG; c.cin = CIN_NCY;
                c.acc_sel = ACC_ALU; c.wr_acc = 1'b1; c.wr_cy = 1'b1;
            end
            4'hA: begin c.acc_sel = ACC_REG; c.wr_acc = 1'b1; end
            4'hB: begin
                c.acc_sel = ACC_REG; c.wr_acc = 1'b1;
                c.reg_sel = REG_ACC; c.wr_reg = 1'b1;
            end
            4'hD: begin c.acc_sel = ACC_OPR; c.wr_acc = 1'b1; end
            4'hF: begin
                case (opr)
                    4'h0: begin c.clr_acc = 1'b1; c.clr_cy = 1'b1; end
                    4'h1: c.clr_cy = 1'b1;
                    4'h2: begin
                        c.op = ALU_ADD; c.in0 = IN0_ACC; c.cin = CIN_ONE;
                        c.acc_sel = ACC_ALU; c.wr_acc = 1'b1; c.wr_cy = 1'b1;
                    end
                    4'h7: begin c.acc_sel = ACC_CY; c.wr_acc = 1'b1; c.clr_cy = 1'b1; end
                    // 4'hF + 0 + 1 always carries out
                    4'hA: begin c.op = ALU_ADD; c.in0 = IN0_F; c.cin = CIN_ONE; c.wr_cy = 1'b1; end
                    default: c = '0;
                endcase
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // rom_addr only moves when a new byte fetch begins, so it holds the
    // address of the last fetched byte through EXEC, ISZ_BR and HALTED.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= FETCH_HI;
            pc           <= '0;
            rom_addr     <= '0;
            nibble_sel   <= 1'b0;
            halt         <= 1'b0;
            opcode       <= '0;
            inst_operand <= '0;
            addr_hi      <= '0;
            addr_lo      <= '0;
            ctrl         <= '0;
        end else begin
            ctrl <= '0;
            case (state)
                FETCH_HI: begin
                    opcode     <= data;
                    nibble_sel <= 1'b1;
                    state      <= FETCH_LO;
                end
                FETCH_LO: begin
                    inst_operand <= data;
                    nibble_sel   <= 1'b0;
                    pc           <= pc + PC_W'(1);
                    if (two_byte) begin
                        rom_addr <= pc + PC_W'(1);
                        state    <= FETCH2_HI;
                    end else begin
                        ctrl  <= decode(opcode, data);
                        state <= EXEC;
                    end
                end
                FETCH2_HI: begin
                    addr_hi    <= data;
                    nibble_sel <= 1'b1;
                    state      <= FETCH2_LO;
                end
                FETCH2_LO: begin
                    addr_lo    <= data;
                    nibble_sel <= 1'b0;
                    pc         <= pc + PC_W'(1);
                    ctrl       <= decode(opcode, inst_operand);
                    state      <= EXEC;
                end
                EXEC: begin
                    state    <= FETCH_HI;
                    rom_addr <= pc;
                    case (opcode)
                        4'h0: if (inst_operand == 4'h1) begin
                            state    <= HALTED;
                            halt     <= 1'b1;
                            rom_addr <= rom_addr;
                        end
                        4'h1: if (take_branch) begin
                            pc       <= target;
                            rom_addr <= target;
                        end
                        4'h4: begin
                            pc       <= target;
                            rom_addr <= target;
                        end
                        4'h7: begin
                            state    <= ISZ_BR;
                            rom_addr <= rom_addr;
                        end
                        default: ;
                    endcase
                end
                ISZ_BR: begin
                    state <= FETCH_HI;
                    if (!reg_is_zero) begin
                        pc       <= target;
                        rom_addr <= target;
                    end else begin
                        rom_addr <= pc;
                    end
                end
                HALTED:  state <= HALTED;
                default: state <= FETCH_HI;
            endcase
        end
    end

    assign clear_carry       = ctrl.clr_cy;
    assign write_carry       = ctrl.wr_cy;
    assign clear_accumulator = ctrl.clr_acc;
    assign write_accumulator = ctrl.wr_acc;
    assign write_register    = ctrl.wr_reg;
    assign acc_input_sel     = ctrl.acc_sel;
    assign reg_input_sel     = ctrl.reg_sel;
    assign alu_op            = ctrl.op;
    assign alu_in0_sel       = ctrl.in0;
    assign alu_in1_sel       = ctrl.in1;
    assign alu_cin_sel       = ctrl.cin;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: ROM + 4-bit datapath model, scoreboard of
// accumulator/carry values expected after each strobe cycle.
module tb_control_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] data;
    logic       take_branch, reg_is_zero;
    logic [7:0] rom_addr;
    logic       nibble_sel, halt;
    logic [3:0] inst_operand;
    logic       clear_carry, write_carry, clear_accumulator, write_accumulator, write_register;
    logic [2:0] acc_input_sel, alu_op, alu_in0_sel;
    logic [1:0] reg_input_sel, alu_in1_sel, alu_cin_sel;

    control_sequencer #(.PC_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .data(data), .take_branch(take_branch),
        .reg_is_zero(reg_is_zero), .rom_addr(rom_addr), .nibble_sel(nibble_sel),
        .halt(halt), .inst_operand(inst_operand), .clear_carry(clear_carry),
        .write_carry(write_carry), .clear_accumulator(clear_accumulator),
        .write_accumulator(write_accumulator), .write_register(write_register),
        .acc_input_sel(acc_input_sel), .reg_input_sel(reg_input_sel), .alu_op(alu_op),
        .alu_in0_sel(alu_in0_sel), .alu_in1_sel(alu_in1_sel), .alu_cin_sel(alu_cin_sel)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [3:0] acc; logic carry; } exp_t;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   wr_count = 0;

    logic [7:0] rom [256];
    logic [3:0] preset [16];
    logic [3:0] regs [16];
    logic [3:0] acc, cur_reg, in0, in1;
    logic       carry, cin;
    logic [4:0] sum;

    assign data        = nibble_sel ? rom[rom_addr][3:0] : rom[rom_addr][7:4];
    assign cur_reg     = regs[inst_operand];
    assign take_branch = (inst_operand[2] && acc == 4'h0) || (inst_operand[1] && carry);
    assign reg_is_zero = (cur_reg == 4'h0);

    always_comb begin
        in0 = 4'h0; in1 = 4'h0; cin = 1'b0;
        case (alu_in0_sel)
            3'd1: in0 = acc;
            3'd2: in0 = cur_reg;
            3'd3: in0 = 4'hF;
            default: in0 = 4'h0;
        endcase
        case (alu_in1_sel)
            2'd1: in1 = cur_reg;
            2'd2: in1 = ~cur_reg;
            default: in1 = 4'h0;
        endcase
        case (alu_cin_sel)
            2'd1: cin = 1'b1;
            2'd2: cin = carry;
            2'd3: cin = ~carry;
            default: cin = 1'b0;
        endcase
        sum = (alu_op == 3'd1) ? ({1'b0, in0} + {1'b0, in1} + {4'b0, cin}) : 5'd0;
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc <= 4'h0;
            carry <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= preset[i];
        end else begin
            if (clear_accumulator) acc <= 4'h0;
            else if (write_accumulator)
                case (acc_input_sel)
                    3'd1: acc <= sum[3:0];
                    3'd2: acc <= cur_reg;
                    3'd3: acc <= inst_operand;
                    3'd4: acc <= {3'b000, carry};
                    default: acc <= 4'h0;
                endcase
            if (clear_carry) carry <= 1'b0;
            else if (write_carry) carry <= sum[4];
            if (write_register)
                regs[inst_operand] <= (reg_input_sel == 2'd1) ? sum[3:0] :
                                      (reg_input_sel == 2'd2) ? acc : 4'h0;
        end
    end

    // Strobe seen at one negedge commits at the next posedge; compare after it.
    logic pending = 1'b0;
    exp_t e;
    always @(negedge clock) begin
        if (pending) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe acc=%h carry=%b required no strobe", acc, carry);
            end else begin
                e = sb.pop_front();
                if (acc !== e.acc || carry !== e.carry) begin
                    errors++;
                    $display("FAIL sb_acc_carry got acc=%h c=%b required acc=%h c=%b",
                             acc, carry, e.acc, e.carry);
                end
            end
        end
        pending = reset_n && (clear_carry || write_carry || clear_accumulator ||
                              write_accumulator || write_register);
        if (reset_n && write_register) wr_count++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [7:0] prog [8]);
        reset_n = 1'b0;
        sb.delete();
        wr_count = 0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        for (int i = 0; i < 16; i++) preset[i] = 4'h0;
        for (int i = 0; i < 8; i++) rom[i] = prog[i];
    endtask

    task automatic start();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic run_to_halt(input string name);
        int n = 0;
        while (!halt && n < 80) begin step(1); n++; end
        step(2);
        checks++;
        if (!halt) begin errors++; $display("FAIL %s_timeout halt=%b required 1", name, halt); end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_left got %0d required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        logic [7:0] p [8] = '{8'h01, 0, 0, 0, 0, 0, 0, 0};
        load(p);
        #1;
        checks++;
        if ({rom_addr, nibble_sel, halt, inst_operand} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0", {rom_addr, nibble_sel, halt, inst_operand});
        end
        checks++;
        if ({clear_carry, write_carry, clear_accumulator, write_accumulator, write_register,
             acc_input_sel, reg_input_sel, alu_op, alu_in0_sel, alu_in1_sel, alu_cin_sel} !== 22'h0) begin
            errors++;
            $display("FAIL reset_strobes got nonzero required 0");
        end
    endtask

    task automatic test_iac_halt();
        logic [7:0] p [8] = '{8'hD5, 8'hF2, 8'h01, 0, 0, 0, 0, 0};
        load(p);
        sb.push_back('{4'h5, 1'b0});
        sb.push_back('{4'h6, 1'b0});
        start();
        step(8);
        checks++;
        if (halt !== 1'b0) begin errors++; $display("FAIL iac_halt_early got %b required 0", halt); end
        step(1);
        checks++;
        if (halt !== 1'b1) begin errors++; $display("FAIL iac_halt_cycle9 got %b required 1", halt); end
        step(4);
        checks++;
        if (rom_addr !== 8'h02 || halt !== 1'b1) begin
            errors++;
            $display("FAIL iac_halt_hold got addr=%h halt=%b required addr=02 halt=1", rom_addr, halt);
        end
        checks++;
        if (sb.size() != 0 || acc !== 4'h6) begin
            errors++;
            $display("FAIL iac_result got acc=%h left=%0d required acc=6 left=0", acc, sb.size());
        end
    endtask

    task automatic test_xch_ld();
        logic [7:0] p [8] = '{8'hD9, 8'hB3, 8'hA3, 8'h01, 0, 0, 0, 0};
        load(p);
        sb.push_back('{4'h9, 1'b0});
        sb.push_back('{4'h0, 1'b0});
        sb.push_back('{4'h9, 1'b0});
        start();
        run_to_halt("xch_ld");
        checks++;
        if (regs[3] !== 4'h9 || acc !== 4'h9) begin
            errors++;
            $display("FAIL xch_ld_regs got r3=%h acc=%h required r3=9 acc=9", regs[3], acc);
        end
        checks++;
        if (wr_count != 1) begin
            errors++;
            $display("FAIL xch_ld_wr_count got %0d required 1", wr_count);
        end
    endtask

    task automatic test_add_jcn();
        logic [7:0] p [8] = '{8'hF0, 8'hD8, 8'h82, 8'h14, 8'h10, 8'h00, 0, 0};
        load(p);
        rom[8'h10] = 8'h01;
        preset[2] = 4'h8;
        sb.push_back('{4'h0, 1'b0});
        sb.push_back('{4'h8, 1'b0});
        sb.push_back('{4'h0, 1'b1});
        start();
        step(13);
        checks++;
        if (rom_addr !== 8'h04) begin
            errors++;
            $display("FAIL jcn_exec_addr got %h required 04", rom_addr);
        end
        step(1);
        checks++;
        if (rom_addr !== 8'h10 || nibble_sel !== 1'b0) begin
            errors++;
            $display("FAIL jcn_target got addr=%h ns=%b required addr=10 ns=0", rom_addr, nibble_sel);
        end
        run_to_halt("add_jcn");
        checks++;
        if (carry !== 1'b1) begin errors++; $display("FAIL add_carry got %b required 1", carry); end
    endtask

    task automatic test_isz();
        logic [7:0] p [8] = '{8'h7E, 8'h00, 8'h01, 0, 0, 0, 0, 0};
        load(p);
        preset[14] = 4'hE;
        sb.push_back('{4'h0, 1'b0});
        sb.push_back('{4'h0, 1'b0});
        start();
        step(5);
        checks++;
        if (regs[14] !== 4'hF || rom_addr !== 8'h01) begin
            errors++;
            $display("FAIL isz_pass1_br got r=%h addr=%h required r=F addr=01", regs[14], rom_addr);
        end
        step(1);
        checks++;
        if (rom_addr !== 8'h00) begin errors++; $display("FAIL isz_branch got %h required 00", rom_addr); end
        step(5);
        checks++;
        if (regs[14] !== 4'h0 || rom_addr !== 8'h01) begin
            errors++;
            $display("FAIL isz_pass2_br got r=%h addr=%h required r=0 addr=01", regs[14], rom_addr);
        end
        step(1);
        checks++;
        if (rom_addr !== 8'h02) begin errors++; $display("FAIL isz_fallthru got %h required 02", rom_addr); end
        run_to_halt("isz");
    endtask

    task automatic test_wrap();
        logic [7:0] p [8] = '{8'h4F, 8'hFF, 0, 0, 0, 0, 0, 0};
        load(p);
        rom[8'hFF] = 8'hD3;
        sb.push_back('{4'h3, 1'b0});
        start();
        step(5);
        checks++;
        if (rom_addr !== 8'hFF) begin errors++; $display("FAIL wrap_jun got %h required FF", rom_addr); end
        step(3);
        checks++;
        if (rom_addr !== 8'h00 || nibble_sel !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pc got addr=%h ns=%b required addr=00 ns=0", rom_addr, nibble_sel);
        end
        @(negedge clock);
        #1;
        checks++;
        if (sb.size() != 0 || acc !== 4'h3) begin
            errors++;
            $display("FAIL wrap_ldm got acc=%h left=%0d required acc=3 left=0", acc, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] p [8] = '{8'h4A, 8'h05, 0, 0, 0, 8'hD7, 8'h01, 0};
        logic any;
        load(p);
        sb.push_back('{4'h7, 1'b0});
        start();
        step(3);
        checks++;
        if (nibble_sel !== 1'b1 || rom_addr !== 8'h01 || inst_operand !== 4'hA) begin
            errors++;
            $display("FAIL mid_pre got ns=%b addr=%h op=%h required ns=1 addr=01 op=A",
                     nibble_sel, rom_addr, inst_operand);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (nibble_sel !== 1'b0 || rom_addr !== 8'h00 || inst_operand !== 4'h0) begin
            errors++;
            $display("FAIL mid_clear got ns=%b addr=%h op=%h required 0 00 0",
                     nibble_sel, rom_addr, inst_operand);
        end
        any = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            any |= clear_carry | write_carry | clear_accumulator | write_accumulator | write_register;
        end
        checks++;
        if (any !== 1'b0) begin errors++; $display("FAIL mid_no_strobe got %b required 0", any); end
        @(negedge clock);
        reset_n = 1'b1;
        step(5);
        checks++;
        if (rom_addr !== 8'h05) begin errors++; $display("FAIL mid_restart got %h required 05", rom_addr); end
        run_to_halt("reset_mid");
    endtask

    task automatic test_carry_ops();
        logic [7:0] p [8] = '{8'hFA, 8'hF7, 8'hD3, 8'h95, 8'hF1, 8'h65, 8'h01, 0};
        load(p);
        preset[5] = 4'h1;
        sb.push_back('{4'h0, 1'b1});
        sb.push_back('{4'h1, 1'b0});
        sb.push_back('{4'h3, 1'b0});
        sb.push_back('{4'h2, 1'b1});
        sb.push_back('{4'h2, 1'b0});
        sb.push_back('{4'h2, 1'b0});
        start();
        run_to_halt("carry_ops");
        checks++;
        if (regs[5] !== 4'h2) begin errors++; $display("FAIL inc_reg got %h required 2", regs[5]); end
    endtask

    initial begin
        test_reset();
        test_iac_halt();
        test_xch_ld();
        test_add_jcn();
        test_isz();
        test_wrap();
        test_reset_mid();
        test_carry_ops();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
